// File: rtl/wts_adsr_envelope_generator_nch.sv
// wts_adsr_envelope_generator_nch: time-multiplexed N-channel ADSR envelope generator with latched key events
module wts_adsr_envelope_generator_nch #(
  parameter int CH_NUM   = 5,
  parameter int ENV_W    = 7,
  parameter int RATE_W   = 8,
  parameter int CH_IDX_W = 3
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [CH_IDX_W-1:0]        active,
  input  logic [CH_NUM-1:0]          key_on,
  input  logic [CH_NUM-1:0]          key_release,
  input  logic [CH_NUM-1:0]          key_off,
  input  logic [CH_NUM*RATE_W-1:0]   reg_ar,
  input  logic [CH_NUM*RATE_W-1:0]   reg_dr,
  input  logic [CH_NUM*RATE_W-1:0]   reg_sr,
  input  logic [CH_NUM*RATE_W-1:0]   reg_rr,
  input  logic [CH_NUM*ENV_W-1:0]    reg_sl,
  output logic [ENV_W-1:0]           envelope,
  output logic [CH_NUM-1:0]          ch_busy
);
  typedef enum logic [2:0] {s_idle, s_attack, s_decay, s_sustain, s_release} state_t;
  localparam logic [ENV_W-1:0]    env_max = {1'b1, {(ENV_W-1){1'b0}}};
  localparam logic [CH_IDX_W-1:0] ch_lim  = CH_IDX_W'(CH_NUM);
  logic [CH_NUM-1:0][2:0]        state_q;
  logic [CH_NUM-1:0][ENV_W-1:0]  level_q;
  logic [CH_NUM-1:0][RATE_W-1:0] cnt_q;
  logic [CH_NUM-1:0]             pend_on, pend_rel, pend_off, clr;
  logic                          sel_ok, ev_on, ev_rel, ev_off, tick;
  logic [CH_IDX_W-1:0]           ch;
  state_t                        st, st_n;
  logic [ENV_W-1:0]              lv, lv_n, lv_up, lv_dn, sl_raw, sl;
  logic [RATE_W-1:0]             ct, ct_n, ct_inc, ar, dr, sr, rr, r;

  assign sel_ok = active < ch_lim;
  assign ch     = sel_ok ? active : '0;
  assign clr    = sel_ok ? CH_NUM'(1) << active : '0;
  assign st     = state_t'(state_q[ch]);
  assign lv     = level_q[ch];
  assign ct     = cnt_q[ch];
  assign ar     = reg_ar[int'(ch)*RATE_W +: RATE_W];
  assign dr     = reg_dr[int'(ch)*RATE_W +: RATE_W];
  assign sr     = reg_sr[int'(ch)*RATE_W +: RATE_W];
  assign rr     = reg_rr[int'(ch)*RATE_W +: RATE_W];
  assign sl_raw = reg_sl[int'(ch)*ENV_W +: ENV_W];
  assign sl     = sl_raw > env_max ? env_max : sl_raw;
  // a pulse in the channel's own slot counts even though it was never latched
  assign ev_off = sel_ok & (pend_off[ch] | key_off[ch]);
  assign ev_on  = sel_ok & (pend_on[ch]  | key_on[ch]);
  assign ev_rel = sel_ok & (pend_rel[ch] | key_release[ch]);
  assign r      = st == s_attack ? ar : st == s_decay ? dr : st == s_sustain ? sr : rr;
  assign tick   = r != '0 && ct >= r - RATE_W'(1);
  assign ct_inc = tick ? '0 : ct + RATE_W'(1);
  assign lv_up  = lv == env_max ? env_max : lv + ENV_W'(1);
  assign lv_dn  = lv == '0 ? '0 : lv - ENV_W'(1);

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state_q  <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      pend_on  <= '0;
      pend_rel <= '0;
      pend_off <= '0;
      envelope <= '0;
    end else begin
      pend_on  <= (pend_on  | key_on)      & ~clr;
      pend_rel <= (pend_rel | key_release) & ~clr;
      pend_off <= (pend_off | key_off)     & ~clr;
      if (sel_ok) begin
        state_q[ch] <= st_n;
        level_q[ch] <= lv_n;
        cnt_q[ch]   <= ct_n;
      end
      envelope <= sel_ok ? lv_n : '0;
    end

  always_comb begin
    st_n = st;
    lv_n = lv;
    ct_n = ct;
    if (ev_off) begin
      st_n = s_idle;
      lv_n = '0;
      ct_n = '0;
    end else if (ev_on) begin
      st_n = ar == '0 ? s_decay : s_attack;
      lv_n = ar == '0 ? env_max : lv;
      ct_n = '0;
    end else if (ev_rel && st inside {s_attack, s_decay, s_sustain}) begin
      st_n = s_release;
      ct_n = '0;
    end else begin
      case (st)
        s_attack:
          if (ar == '0) begin
            lv_n = env_max;
            st_n = s_decay;
            ct_n = '0;
          end else begin
            ct_n = ct_inc;
            if (tick) begin
              lv_n = lv_up;
              st_n = lv_up == env_max ? s_decay : s_attack;
            end
          end
        s_decay:
          if (lv <= sl || dr == '0) begin
            lv_n = lv <= sl ? lv : sl;
            st_n = s_sustain;
            ct_n = '0;
          end else begin
            ct_n = ct_inc;
            if (tick) begin
              lv_n = lv_dn;
              st_n = lv_dn == sl ? s_sustain : s_decay;
            end
          end
        s_sustain:
          if (sr != '0) begin
            ct_n = ct_inc;
            lv_n = tick ? lv_dn : lv;
          end
        s_release:
          if (rr != '0) begin
            ct_n = ct_inc;
            if (tick) begin
              lv_n = lv_dn;
              st_n = lv_dn == '0 ? s_idle : s_release;
            end
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < CH_NUM; i++) ch_busy[i] = state_q[i] != s_idle;
  end
endmodule
